// File: rtl/dac_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dac_playback_ctrl
// Description : Buffers 8-bit samples in a FIFO. A start/prime/run state
//               machine plays them out to an external DAC at a programmable
//               rate (hclk cycles per sample). Single clock domain.
//               Optional macro DAC_IDLE_MIDSCALE_EN: dac_data is forced to
//               0x80 on reset, on stop and on underrun ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_playback_ctrl #(
    parameter int DEPTH  = 256,
    parameter int DIV_W  = 16,
    parameter int UCNT_W = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    input  logic              start,
    input  logic              stop,
    input  logic              flush,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic [LW-1:0]     prime_level,
    output logic              busy,
    output logic [LW-1:0]     fifo_level,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_count,
    output logic [7:0]        dac_data,
    output logic              dac_clk
);

`ifdef DAC_IDLE_MIDSCALE_EN
    localparam logic [7:0] c_IDLE_CODE = 8'h80;
    localparam logic       c_MIDSCALE  = 1'b1;
`else
    localparam logic [7:0] c_IDLE_CODE = 8'h00;
    localparam logic       c_MIDSCALE  = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    logic [7:0]        r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;

    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_half;
    logic [DIV_W-1:0]  r_cnt;
    logic [LW-1:0]     r_prime;
    logic              r_underrun;
    logic [UCNT_W-1:0] r_ucnt;
    logic [7:0]        r_dac;
    logic              r_dclk;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_tick;
    logic              w_pop;
    logic [DIV_W-1:0]  w_cnt_nxt;
    logic [DIV_W-1:0]  w_div_lat;
    logic [LW-1:0]     w_prime_lat;

    assign w_full      = (r_level == LW'(DEPTH));
    assign w_empty     = (r_level == '0);
    // A push at full is refused even if a pop frees a slot this cycle.
    assign w_push      = wr_valid && !w_full && !flush;
    // stop takes precedence over a coincident sample tick.
    assign w_tick      = (r_state == S_RUN) && (r_cnt == '0) && !stop;
    assign w_pop       = w_tick && !w_empty;
    assign w_cnt_nxt   = (r_cnt == r_div - 1'b1) ? '0 : r_cnt + 1'b1;
    assign w_div_lat   = (rate_div < DIV_W'(2)) ? DIV_W'(2) : rate_div;
    assign w_prime_lat = (prime_level > LW'(DEPTH)) ? LW'(DEPTH) : prime_level;

    assign wr_ready       = !w_full;
    assign busy           = (r_state != S_IDLE);
    assign fifo_level     = r_level;
    assign underrun       = r_underrun;
    assign underrun_count = r_ucnt;
    assign dac_data       = r_dac;
    assign dac_clk        = r_dclk;

    // Sample storage; emptiness is tracked by the pointers, so no reset here.
    always_ff @(posedge hclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; flush wins over any push.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // Playback state machine, rate divider, DAC strobe and sample register.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state    <= S_IDLE;
            r_div      <= DIV_W'(2);
            r_half     <= DIV_W'(1);
            r_cnt      <= '0;
            r_prime    <= '0;
            r_underrun <= 1'b0;
            r_ucnt     <= '0;
            r_dac      <= c_IDLE_CODE;
            r_dclk     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_state    <= S_PRIME;
                        r_div      <= w_div_lat;
                        r_half     <= w_div_lat >> 1;
                        r_prime    <= w_prime_lat;
                        r_underrun <= 1'b0;
                        r_ucnt     <= '0;
                    end
                end
                S_PRIME: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        if (c_MIDSCALE) begin
                            r_dac <= c_IDLE_CODE;
                        end
                    end else if (r_level >= r_prime) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_dclk  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_dclk  <= 1'b0;
                        if (c_MIDSCALE) begin
                            r_dac <= c_IDLE_CODE;
                        end
                    end else begin
                        // Strobe is registered against the next count so it
                        // stays aligned with r_cnt: low on the tick half,
                        // high from floor(N/2) onward.
                        r_cnt  <= w_cnt_nxt;
                        r_dclk <= (w_cnt_nxt >= r_half);
                        if (w_pop) begin
                            r_dac <= r_mem[r_rptr];
                        end else if (w_tick) begin
                            r_underrun <= 1'b1;
                            if (r_ucnt != {UCNT_W{1'b1}}) begin
                                r_ucnt <= r_ucnt + 1'b1;
                            end
                            if (c_MIDSCALE) begin
                                r_dac <= c_IDLE_CODE;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_dclk  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_playback_ctrl
// Description : Self-checking bench for dac_playback_ctrl. A queue-based
//               playback model is compared against the DUT every cycle;
//               directed scenarios add literal expectations, followed by a
//               randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_playback_ctrl;

    localparam int DEPTH  = 16;
    localparam int DIV_W  = 8;
    localparam int UCNT_W = 4;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int UMAX   = (1 << UCNT_W) - 1;
`ifdef DAC_IDLE_MIDSCALE_EN
    localparam bit   MID     = 1'b1;
    localparam logic [7:0] RST_DAC = 8'h80;
`else
    localparam bit   MID     = 1'b0;
    localparam logic [7:0] RST_DAC = 8'h00;
`endif

    logic              hclk = 1'b0;
    logic              hreset;
    logic              wr_valid;
    logic [7:0]        wr_data;
    logic              wr_ready;
    logic              start;
    logic              stop;
    logic              flush;
    logic [DIV_W-1:0]  rate_div;
    logic [LW-1:0]     prime_level;
    logic              busy;
    logic [LW-1:0]     fifo_level;
    logic              underrun;
    logic [UCNT_W-1:0] underrun_count;
    logic [7:0]        dac_data;
    logic              dac_clk;

    dac_playback_ctrl #(.DEPTH(DEPTH), .DIV_W(DIV_W), .UCNT_W(UCNT_W)) dut (
        .hclk(hclk), .hreset(hreset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .start(start), .stop(stop), .flush(flush),
        .rate_div(rate_div), .prime_level(prime_level), .busy(busy),
        .fifo_level(fifo_level), .underrun(underrun),
        .underrun_count(underrun_count), .dac_data(dac_data), .dac_clk(dac_clk)
    );

    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: queue of samples, mode 0=idle 1=prime 2=run, k = cycle within
    // the current sample period (0 = tick).
    logic [7:0] m_q[$];
    int         m_mode, m_k, m_N, m_P, m_ucnt;
    bit         m_und;
    logic [7:0] m_dac;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_mode = 0; m_k = 0; m_N = 2; m_P = 0; m_ucnt = 0; m_und = 0;
        m_dac = RST_DAC;
    endtask

    task automatic compare_all();
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        chk("wr_ready", 32'(wr_ready), 32'(m_q.size() < DEPTH));
        chk("underrun", 32'(underrun), 32'(m_und));
        chk("underrun_count", 32'(underrun_count), 32'(m_ucnt));
        chk("dac_data", 32'(dac_data), 32'(m_dac));
        chk("dac_clk", 32'(dac_clk), 32'((m_mode == 2) && (m_k >= m_N / 2)));
    endtask

    task automatic model_step(input bit wv, input logic [7:0] wd, input bit st,
                              input bit sp, input bit fl, input int rd, input int pl);
        int sz;
        bit acc, tick;
        sz   = m_q.size();
        acc  = wv && (sz < DEPTH) && !fl;
        tick = (m_mode == 2) && (m_k == 0) && !sp;
        if (tick) begin
            if (sz > 0) m_dac = m_q.pop_front();
            else begin
                m_und = 1'b1;
                if (m_ucnt < UMAX) m_ucnt++;
                if (MID) m_dac = 8'h80;
            end
        end
        if (fl) m_q.delete();
        else if (acc) m_q.push_back(wd);
        if (m_mode != 0 && sp) begin
            m_mode = 0; m_k = 0;
            if (MID) m_dac = 8'h80;
        end else if (m_mode == 0 && st && !sp) begin
            m_mode = 1;
            m_N = (rd < 2) ? 2 : rd;
            m_P = (pl > DEPTH) ? DEPTH : pl;
            m_und = 1'b0; m_ucnt = 0;
        end else if (m_mode == 1 && sz >= m_P) begin
            m_mode = 2; m_k = 0;
        end else if (m_mode == 2) begin
            m_k = (m_k + 1) % m_N;
        end
    endtask

    // Called at a negedge: drive, advance model, cross posedge, compare.
    task automatic cyc(input bit wv, input logic [7:0] wd, input bit st, input bit sp,
                       input bit fl, input int rd, input int pl);
        wr_valid = wv; wr_data = wd; start = st; stop = sp; flush = fl;
        rate_div = DIV_W'(rd); prime_level = LW'(pl);
        model_step(wv, wd, st, sp, fl, rd, pl);
        @(posedge hclk);
        @(negedge hclk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        wr_valid = 0; start = 0; stop = 0; flush = 0;
        hreset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dac_clk", 32'(dac_clk), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        model_reset();
        @(posedge hclk);
        @(negedge hclk);
        hreset = 1'b0;
        compare_all();
    endtask

    initial begin
        hreset = 1'b1; wr_valid = 0; wr_data = 0; start = 0; stop = 0; flush = 0;
        rate_div = 0; prime_level = 0;
        model_reset();
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
        chk("reset_dac_data", 32'(dac_data), 32'(RST_DAC));
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        chk("reset_ucnt", 32'(underrun_count), 32'd0);
        compare_all();

        // Four samples, N=4, P=4.
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h10 * (i + 1)), 0, 0, 0, 0, 0);
        chk("t1_level", 32'(fifo_level), 32'd4);
        cyc(0, 8'h00, 1, 0, 0, 4, 4);
        chk("t1_busy", 32'(busy), 32'd1);
        idle(1);
        chk("t1_entry_dac", 32'(dac_data), 32'(RST_DAC));
        idle(1);
        chk("t1_first_sample", 32'(dac_data), 32'h10);
        chk("t1_clk_low_cnt1", 32'(dac_clk), 32'd0);
        idle(1);
        chk("t1_clk_high_cnt2", 32'(dac_clk), 32'd1);
        idle(17);
        chk("t2_underrun", 32'(underrun), 32'd1);
        chk("t2_ucnt1", 32'(underrun_count), 32'd1);
        chk("t2_dac_hold", 32'(dac_data), MID ? 32'h80 : 32'h40);
        idle(8);
        chk("t2_ucnt3", 32'(underrun_count), 32'd3);
        idle(50);
        chk("t2_ucnt_sat", 32'(underrun_count), 32'(UMAX));
        cyc(0, 8'h00, 0, 1, 0, 0, 0);

        // Fill to DEPTH, refuse extra write, concurrent pop at full.
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'hA0 + i), 0, 0, 0, 0, 0);
        chk("t3_full_ready", 32'(wr_ready), 32'd0);
        chk("t3_full_level", 32'(fifo_level), 32'(DEPTH));
        cyc(1, 8'hEE, 0, 0, 0, 0, 0);
        chk("t3_no_overfill", 32'(fifo_level), 32'(DEPTH));
        cyc(1, 8'hEE, 1, 0, 0, 2, 0);
        cyc(1, 8'hEE, 0, 0, 0, 0, 0);
        cyc(1, 8'hEE, 0, 0, 0, 0, 0);
        chk("t3_pop_at_full", 32'(fifo_level), 32'(DEPTH - 1));
        idle(40);
        cyc(0, 8'h00, 0, 1, 0, 0, 0);

        // rate_div 0 and 1 clamp to 2.
        for (int r = 0; r < 2; r++) begin
            cyc(0, 8'h00, 0, 0, 1, 0, 0);
            for (int i = 0; i < 6; i++) cyc(1, 8'(8'h50 + 16 * r + i), 0, 0, 0, 0, 0);
            cyc(0, 8'h00, 1, 0, 0, r, 2);
            idle(20);
            cyc(0, 8'h00, 0, 1, 0, 0, 0);
        end

        // Prime gating with P=8.
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 8'(8'h31 + i), 0, 0, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 3, 8);
        idle(4);
        chk("t5_prime_busy", 32'(busy), 32'd1);
        chk("t5_prime_hold", 32'(fifo_level), 32'd3);
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h34 + i), 0, 0, 0, 0, 0);
        idle(1);
        chk("t5_run_entry_level", 32'(fifo_level), 32'd8);
        idle(1);
        chk("t5_first_pop", 32'(fifo_level), 32'd7);
        chk("t5_first_data", 32'(dac_data), 32'h31);
        cyc(0, 8'h00, 0, 1, 0, 0, 0);
        cyc(0, 8'h00, 1, 1, 0, 4, 0);
        chk("t5_start_stop_idle", 32'(busy), 32'd0);

        // Flush during RUN, then async reset mid-RUN.
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 8'(8'h70 + i), 0, 0, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 4, 10);
        idle(5);
        cyc(0, 8'h00, 0, 0, 1, 0, 0);
        chk("t6_flush_level", 32'(fifo_level), 32'd0);
        idle(6);
        chk("t6_flush_underrun", 32'(underrun), 32'd1);
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h90 + i), 0, 0, 0, 0, 0);
        idle(2);
        do_reset();

        // Randomized phase.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 999) < 2) do_reset();
            else cyc($urandom_range(0, 1) == 1, 8'($urandom),
                     $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 1,
                     $urandom_range(0, 199) < 1,
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 20)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
